// File: rtl/lector_destinos.sv
// lector_destinos: round-robin egress reader merging the D0/D1 destination FIFOs.
// Destination-bit checking is compiled in when LECTOR_DEST_CHECK_EN is defined.
module lector_destinos #(
    parameter int BW = 6,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          enable,
    input  logic          D0_empty,
    input  logic          D1_empty,
    input  logic          D0_error_output,
    input  logic          D1_error_output,
    input  logic [BW-1:0] D0_data_out,
    input  logic [BW-1:0] D1_data_out,
    output logic          D0_rd,
    output logic          D1_rd,
    input  logic          out_stall,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          src_out,
    output logic [CW-1:0] cnt_D0,
    output logic [CW-1:0] cnt_D1,
    output logic          error_out,
    output logic          dest_mismatch
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ERROR
    } state_t;

    state_t        state_q;
    logic          last_q;
    logic          inflight_q;
    logic          inflight_src_q;
    logic          skid_vld_q;
    logic          skid_src_q;
    logic [BW-1:0] skid_data_q;
    logic [BW-1:0] data_q;
    logic          valid_q;
    logic          src_q;
    logic [CW-1:0] cnt0_q;
    logic [CW-1:0] cnt1_q;
    logic          err_q;
    logic          mis_q;

    logic          sel;
    logic          sel_empty;
    logic          issue;
    logic          accept;
    logic          deliver;
    logic          any_err;
    logic          mis_hit;
    logic          all_empty;
    logic [BW-1:0] cap_data;

    // last_q = 1 means D1 was served last, so D0 wins a tie
    always_comb begin
        sel = D0_empty;
        if (!D0_empty && !D1_empty) begin
            sel = ~last_q;
        end
    end

    assign sel_empty = sel ? D1_empty : D0_empty;
    assign issue     = (state_q == ACTIVE) && enable && !out_stall
                     && !skid_vld_q && !sel_empty;
    assign D0_rd     = issue && !sel;
    assign D1_rd     = issue && sel;

    assign cap_data  = inflight_src_q ? D1_data_out : D0_data_out;
    assign accept    = !valid_q || !out_stall;
    assign deliver   = valid_q && !out_stall;
    assign all_empty = D0_empty && D1_empty;
    assign any_err   = D0_error_output || D1_error_output || mis_q;

`ifdef LECTOR_DEST_CHECK_EN
    assign mis_hit = inflight_q && (cap_data[BW-2] != inflight_src_q);
`else
    assign mis_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_err) begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                    end else if (enable && !all_empty) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (any_err) begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                    end else if (all_empty && !inflight_q
                                 && !skid_vld_q && !valid_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= ERROR;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            last_q         <= 1'b1;
            inflight_q     <= 1'b0;
            inflight_src_q <= 1'b0;
            skid_vld_q     <= 1'b0;
            skid_src_q     <= 1'b0;
            skid_data_q    <= '0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            src_q          <= 1'b0;
            mis_q          <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_src_q <= sel;
                last_q         <= sel;
            end
            mis_q <= mis_q | mis_hit;
            // Skid entry always drains ahead of a newly captured word
            if (accept) begin
                if (skid_vld_q) begin
                    data_q     <= skid_data_q;
                    src_q      <= skid_src_q;
                    valid_q    <= 1'b1;
                    skid_vld_q <= inflight_q;
                    if (inflight_q) begin
                        skid_data_q <= cap_data;
                        skid_src_q  <= inflight_src_q;
                    end
                end else if (inflight_q) begin
                    data_q  <= cap_data;
                    src_q   <= inflight_src_q;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end else if (inflight_q) begin
                skid_vld_q  <= 1'b1;
                skid_data_q <= cap_data;
                skid_src_q  <= inflight_src_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (deliver) begin
            if (src_q) begin
                if (cnt1_q != {CW{1'b1}}) cnt1_q <= cnt1_q + CW'(1);
            end else begin
                if (cnt0_q != {CW{1'b1}}) cnt0_q <= cnt0_q + CW'(1);
            end
        end
    end

    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign src_out       = src_q;
    assign cnt_D0        = cnt0_q;
    assign cnt_D1        = cnt1_q;
    assign error_out     = err_q;
    assign dest_mismatch = mis_q;

endmodule
